// File: rtl/bits_to_bytes_pkg.sv
// bits_to_bytes shared types and the LSB-first flat-to-byte slice.
// Holds byte width, byte type and the flat_to_bytes() helper.
package bits_to_bytes_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_BYTES = 64;
  localparam int MAX_W     = MAX_BYTES * BYTE_W;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef byte_t [MAX_BYTES-1:0] bytes_max_t;

  // Byte i takes bits [i*8+7 : i*8]; no bit reversal, no byte swap.
  function automatic bytes_max_t flat_to_bytes(
    input logic [MAX_W-1:0] flat
  );
    bytes_max_t r;
    for (int i = 0; i < MAX_BYTES; i++) begin
      r[i] = flat[i*BYTE_W +: BYTE_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/bits_to_bytes_if.sv
// bits_to_bytes stream bus: bit-vector input side, byte-array output side.
// Ports: bits_i/valid_i/ready_o upstream, bytes_o/valid_o/ready_i downstream.
interface bits_to_bytes_if
  import bits_to_bytes_pkg::*;
#(
  parameter int N_BYTES = 4
);

  logic [N_BYTES*BYTE_W-1:0] bits_i;
  logic                      valid_i;
  logic                      ready_o;
  byte_t [N_BYTES-1:0]       bytes_o;
  logic                      valid_o;
  logic                      ready_i;

  modport slave (
    input  bits_i,
    input  valid_i,
    input  ready_i,
    output ready_o,
    output bytes_o,
    output valid_o
  );

  modport master (
    output bits_i,
    output valid_i,
    output ready_i,
    input  ready_o,
    input  bytes_o,
    input  valid_o
  );

endinterface

// File: rtl/bits_to_bytes_skid.sv
// Generic 2-entry valid/ready skid stage: output register plus skid register.
// Ports: clk_i, rst_i, i_data/i_valid/o_ready in, o_data/o_valid/i_ready out.
module bits_to_bytes_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_full;

  logic w_in_fire;
  logic w_out_fire;

  // ready comes straight from a flop, never from i_ready
  assign w_in_fire  = i_valid && !r_skid_full;
  assign w_out_fire = r_out_valid && i_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_skid_data <= '0;
      r_skid_full <= 1'b0;
    end else if (w_out_fire) begin
      // skid full implies no input this edge
      if (r_skid_full) begin
        r_out_data  <= r_skid_data;
        r_skid_full <= 1'b0;
      end else if (w_in_fire) begin
        r_out_data  <= i_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      if (!r_out_valid) begin
        r_out_data  <= i_data;
        r_out_valid <= 1'b1;
      end else begin
        r_skid_data <= i_data;
        r_skid_full <= 1'b1;
      end
    end
  end

  assign o_ready = !r_skid_full;
  assign o_data  = r_out_data;
  assign o_valid = r_out_valid;

endmodule

// File: rtl/bits_to_bytes.sv
// bits_to_bytes top: registered skid stage, then LSB-first byte slicing.
// Ports: clk_i, rst_i, bus (slave side of bits_to_bytes_if).
module bits_to_bytes
  import bits_to_bytes_pkg::*;
#(
  parameter int N_BYTES = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  bits_to_bytes_if.slave bus
);

  localparam int W = N_BYTES * BYTE_W;

  logic [W-1:0]     w_data;
  logic [MAX_W-1:0] w_flat;
  bytes_max_t       w_bytes;

  bits_to_bytes_skid #(
    .WIDTH(W)
  ) u_skid (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_data (bus.bits_i),
    .i_valid(bus.valid_i),
    .o_ready(bus.ready_o),
    .o_data (w_data),
    .o_valid(bus.valid_o),
    .i_ready(bus.ready_i)
  );

  always_comb begin
    w_flat        = '0;
    w_flat[W-1:0] = w_data;
  end

  assign w_bytes     = flat_to_bytes(w_flat);
  assign bus.bytes_o = w_bytes[N_BYTES-1:0];

endmodule

// File: tb/tb_bits_to_bytes.sv
// Self-checking bench for bits_to_bytes with a queue scoreboard.
// Drives and samples on the falling edge, away from the active edge.
module tb_bits_to_bytes;
  import bits_to_bytes_pkg::*;

  localparam int N = 4;
  localparam int W = N * BYTE_W;

  typedef byte_t [N-1:0] word_t;

  logic clk;
  logic rst;

  bits_to_bytes_if #(.N_BYTES(N)) bus ();

  bits_to_bytes #(.N_BYTES(N)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int    total;
  int    passed;
  word_t q[$];
  logic  hold_pend;
  word_t held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t expect_of(input logic [W-1:0] d);
    bytes_max_t wide;
    logic [MAX_W-1:0] f;
    f = '0;
    f[W-1:0] = d;
    wide = flat_to_bytes(f);
    return wide[N-1:0];
  endfunction

  // One cycle: drive at negedge, judge transfers, wait next negedge.
  task automatic cycle(input logic v, input logic [W-1:0] d,
                       input logic r);
    word_t exp;
    bus.valid_i = v;
    bus.bits_i  = d;
    bus.ready_i = r;
    #1;
    if (hold_pend) begin
      total++;
      if (bus.valid_o === 1'b1 && bus.bytes_o === held) passed++;
      else $display("FAIL stable: got v=%b %h want v=1 %h",
                    bus.valid_o, bus.bytes_o, held);
    end
    if (bus.valid_o === 1'b1 && r) begin
      total++;
      if (q.size() == 0) begin
        $display("FAIL sb_extra: got %h want nothing", bus.bytes_o);
      end else begin
        exp = q.pop_front();
        if (bus.bytes_o === exp) passed++;
        else $display("FAIL sb_data: got %h want %h", bus.bytes_o, exp);
      end
    end
    if (v && bus.ready_o === 1'b1) q.push_back(expect_of(d));
    hold_pend = (bus.valid_o === 1'b1) && !r;
    held      = bus.bytes_o;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.valid_i = 1'b1;
    bus.bits_i  = 32'hA5A5A5A5;
    bus.ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete();
    hold_pend = 1'b0;
    total++;
    if (bus.valid_o === 1'b0 && bus.ready_o === 1'b1 &&
        bus.bytes_o === '0) passed++;
    else $display("FAIL reset: got v=%b r=%b %h want v=0 r=1 0",
                  bus.valid_o, bus.ready_o, bus.bytes_o);
  endtask

  task automatic test_pattern();
    cycle(1'b1, 32'h89ABCDEF, 1'b1);
    total++;
    if (bus.valid_o === 1'b1 && bus.bytes_o[3] === 8'h89 &&
        bus.bytes_o[2] === 8'hAB && bus.bytes_o[1] === 8'hCD &&
        bus.bytes_o[0] === 8'hEF) passed++;
    else $display("FAIL pattern: got v=%b %h want v=1 89abcdef",
                  bus.valid_o, bus.bytes_o);
    cycle(1'b0, '0, 1'b1);
    total++;
    if (bus.valid_o === 1'b0) passed++;
    else $display("FAIL one_cycle: got v=%b want 0", bus.valid_o);
  endtask

  task automatic test_extremes();
    cycle(1'b1, 32'h00000000, 1'b1);
    total++;
    if (bus.valid_o === 1'b1 && bus.bytes_o === 32'h0 &&
        bus.ready_o === 1'b1) passed++;
    else $display("FAIL zeros: got v=%b r=%b %h want v=1 r=1 0",
                  bus.valid_o, bus.ready_o, bus.bytes_o);
    cycle(1'b1, 32'hFFFFFFFF, 1'b1);
    total++;
    if (bus.valid_o === 1'b1 && bus.bytes_o === 32'hFFFFFFFF &&
        bus.ready_o === 1'b1) passed++;
    else $display("FAIL ones: got v=%b r=%b %h want v=1 r=1 ffffffff",
                  bus.valid_o, bus.ready_o, bus.bytes_o);
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_increment();
    cycle(1'b1, 32'h03020100, 1'b1);
    for (int i = 0; i < N; i++) begin
      total++;
      if (bus.bytes_o[i] === 8'(i)) passed++;
      else $display("FAIL incr_b%0d: got %h want %h",
                    i, bus.bytes_o[i], 8'(i));
    end
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 32'h11223344, 1'b0);
    cycle(1'b1, 32'h55667788, 1'b0);
    total++;
    if (bus.ready_o === 1'b0 && bus.bytes_o === 32'h11223344 &&
        bus.valid_o === 1'b1) passed++;
    else $display("FAIL bp_full: got r=%b v=%b %h want r=0 v=1 11223344",
                  bus.ready_o, bus.valid_o, bus.bytes_o);
    cycle(1'b1, 32'h99AABBCC, 1'b0);
    total++;
    if (bus.ready_o === 1'b0 && bus.bytes_o === 32'h11223344)
      passed++;
    else $display("FAIL bp_stall: got r=%b %h want r=0 11223344",
                  bus.ready_o, bus.bytes_o);
    cycle(1'b1, 32'h99AABBCC, 1'b1);
    total++;
    if (bus.bytes_o === 32'h55667788 && bus.ready_o === 1'b1) passed++;
    else $display("FAIL bp_b: got r=%b %h want r=1 55667788",
                  bus.ready_o, bus.bytes_o);
    cycle(1'b1, 32'h99AABBCC, 1'b1);
    total++;
    if (bus.bytes_o === 32'h99AABBCC && bus.valid_o === 1'b1) passed++;
    else $display("FAIL bp_c: got v=%b %h want v=1 99aabbcc",
                  bus.valid_o, bus.bytes_o);
    cycle(1'b0, '0, 1'b1);
    total++;
    if (q.size() == 0 && bus.valid_o === 1'b0) passed++;
    else $display("FAIL bp_drain: got q=%0d v=%b want q=0 v=0",
                  q.size(), bus.valid_o);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 32'h01234567, 1'b0);
    cycle(1'b1, 32'h76543210, 1'b0);
    rst = 1'b1;
    bus.valid_i = 1'b1;
    bus.bits_i  = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    hold_pend = 1'b0;
    total++;
    if (bus.valid_o === 1'b0 && bus.ready_o === 1'b1 &&
        bus.bytes_o === '0) passed++;
    else $display("FAIL rst_mid: got v=%b r=%b %h want v=0 r=1 0",
                  bus.valid_o, bus.ready_o, bus.bytes_o);
    cycle(1'b1, 32'hDEADBEEF, 1'b1);
    total++;
    if (bus.valid_o === 1'b1 && bus.bytes_o[0] === 8'hEF &&
        bus.bytes_o[1] === 8'hBE && bus.bytes_o[2] === 8'hAD &&
        bus.bytes_o[3] === 8'hDE) passed++;
    else $display("FAIL rst_new: got v=%b %h want v=1 deadbeef",
                  bus.valid_o, bus.bytes_o);
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    logic v;
    logic r;
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      cycle(v, W'($urandom), r);
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      cycle(1'b0, '0, 1'b1);
    end
    total++;
    if (q.size() == 0 && bus.valid_o === 1'b0) passed++;
    else $display("FAIL rand_drain: got q=%0d v=%b want q=0 v=0",
                  q.size(), bus.valid_o);
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    hold_pend = 1'b0;
    held      = '0;
    rst       = 1'b1;
    bus.valid_i = 1'b0;
    bus.bits_i  = '0;
    bus.ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_pattern();
    test_extremes();
    test_increment();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bits_to_bytes.md
Name: bits_to_bytes

Overview:
- Converts a flat packed bit vector of N_BYTES*8 bits into a packed array of N_BYTES bytes, LSB-first: byte i is bits [i*8+7 : i*8].
- Wraps the mapping in a registered valid/ready stream stage with a 2-entry skid buffer, giving full throughput under backpressure.
- Sits between bit-oriented producers (hash/sampler outputs) and byte-oriented consumers in the conversion/compression datapath.

Parameters:
- N_BYTES, 4, number of output bytes; legal range 1..64; input width is N_BYTES*8.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- bits_i  input  N_BYTES*8  input bit vector; bit 0 is the LSB of byte 0.
- valid_i  input  1  bits_i is valid this cycle.
- ready_o  output  1  block can accept an input this cycle.
- bytes_o  output  [N_BYTES-1:0][7:0]  packed byte array; bytes_o[i] = captured bits_i[i*8 +: 8].
- valid_o  output  1  bytes_o holds a valid word.
- ready_i  input  1  downstream accepts bytes_o this cycle.

Behaviour:
- Mapping is pure wiring, with no bit reversal and no byte swap. bytes_o as a flat vector is bit-identical to the accepted bits_i.
- Input transfer occurs on a rising edge with valid_i && ready_o.
- Output transfer occurs on a rising edge with valid_o && ready_i.
- Latency: a word accepted at edge k appears on bytes_o with valid_o=1 after edge k, i.e. 1 cycle.
- Storage is one main (output) register plus one skid register.
  - ready_o = !skid_full. It is registered and does not depend combinationally on ready_i.
- Accepting into an empty or draining stage:
  - If the output register is empty, or is being consumed this edge, the input loads the output register.
  - Otherwise the input loads the skid register, and skid_full is set.
- Skid handling:
  - When the output is consumed while skid_full, the skid contents move to the output register and skid_full clears.
  - If a new input arrives on that same edge, it is not possible, because ready_o=0 while skid_full.
- While valid_o=1 and ready_i=0, bytes_o and valid_o stay stable. No word is ever dropped, duplicated or reordered.
- Simultaneous accept and consume with an empty skid: the output register reloads with the new word and valid_o stays 1.
- Reset values: valid_o=0, skid_full=0, ready_o=1 in the first cycle after reset. bytes_o resets to all zeros.
- Reset mid-operation: any in-flight words (output and skid) are discarded. The next edge after rst_i deasserts behaves as empty.
- valid_i is ignored while rst_i=1.
- bits_i values when valid_i=0 have no effect. Data registers load only on transfer.

Decomposition:
- Package bits_to_bytes_pkg holds:
  - localparam BYTE_W = 8.
  - typedef logic [BYTE_W-1:0] byte_t.
  - A function flat_to_bytes() performing the LSB-first slice. The bench reuses it for expected values.
- One sub-module, bits_to_bytes_skid: a generic-width 2-entry valid/ready skid register with a WIDTH parameter.
- The top instantiates bits_to_bytes_skid with WIDTH = N_BYTES*8 and applies flat_to_bytes on its output.

Test Plan:
- Pattern, N_BYTES=4, ready_i=1: send 0x89ABCDEF. One cycle later bytes_o[3..0] = 89,AB,CD,EF, with valid_o=1 for exactly one cycle.
- Extremes: send 0x00000000, then 0xFFFFFFFF, back-to-back with ready_i=1.
  - Output is all-zero bytes, then all 0xFF bytes, on consecutive cycles.
  - ready_o stays 1 throughout.
- Incrementing: send 0x03020100. Each bytes_o[i] equals i (00,01,02,03).
- Backpressure:
  - Stream words A=0x11223344, B=0x55667788, C=0x99AABBCC with ready_i=0 from the cycle after A.
  - Expect A held stable on bytes_o, B captured in skid, and ready_o=0, so C is stalled.
  - Raise ready_i: A, B and C emerge in order, one per cycle, with no loss.
- Reset mid-stream:
  - With two words buffered, assert rst_i for 1 cycle.
  - Expect valid_o=0, ready_o=1 and bytes_o=0 the cycle after reset.
  - A new word 0xDEADBEEF then emerges as EF,BE,AD,DE after 1 cycle.
- Random: 1000 random words with random valid_i/ready_i. A scoreboard checks order and flat_to_bytes mapping, and checks bytes_o stability whenever valid_o && !ready_i.
